// File: rtl/seq_pkg.sv
// seq_pkg: state encodings, opcodes, ALU codes and instruction classes for multicycle_sequencer
package seq_pkg;
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd7;

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h8;

    typedef enum logic [1:0] {CLS_R, CLS_LOAD, CLS_STORE, CLS_BRANCH} cls_t;
endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode decoder, maps the IR opcode to an instruction class and legal flag
module seq_decode
    import seq_pkg::*;
(
    input  logic [6:0] opcode,
    output cls_t       cls,
    output logic       legal
);
    assign cls   = (opcode == OP_LOAD)   ? CLS_LOAD   :
                   (opcode == OP_STORE)  ? CLS_STORE  :
                   (opcode == OP_BRANCH) ? CLS_BRANCH : CLS_R;
    assign legal = (opcode == OP_R) || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE) || (opcode == OP_BRANCH);
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with sticky trap state.
// Optional ack timeout enabled by defining SEQ_TIMEOUT_EN.
module multicycle_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        ir_we,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [2:0]  state,
    output logic        trap
);
    logic [2:0]  state_nxt;
    logic [31:0] ir;
    logic        go;
    cls_t        cls;
    logic        legal, active, is_r, is_ld, is_st, is_br, beq_ok, timeout;
    logic        unused_ir;

    seq_decode u_dec (.opcode(ir[6:0]), .cls(cls), .legal(legal));

    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
    assign is_r   = cls == CLS_R;
    assign is_ld  = cls == CLS_LOAD;
    assign is_st  = cls == CLS_STORE;
    assign is_br  = cls == CLS_BRANCH;
    assign beq_ok = is_br && ir[14:12] == 3'd0;
    // Operand controls derive from the stable IR, so they hold from EXEC through MEM and WB
    assign active     = state == ST_EXEC || state == ST_MEM || state == ST_WB;
    assign alu_op     = !active ? 4'h0 : is_r ? {ir[30], ir[14:12]} : is_br ? ALU_SUB : ALU_ADD;
    assign alu_src    = active && (is_ld || is_st);
    assign mem_to_reg = active && is_ld;
    assign dmem_we    = active && is_st;
    // go holds off the first fetch request until the first edge after reset release
    assign imem_req = state == ST_FETCH && go;
    assign ir_we    = imem_req && imem_ack;
    assign dmem_req = state == ST_MEM;
    assign reg_we   = state == ST_WB;
    assign pc_we    = (state == ST_EXEC && beq_ok) || (dmem_req && is_st && dmem_ack) || reg_we;
    assign pc_src   = state == ST_EXEC && beq_ok && alu_zero;
    assign trap     = state == ST_TRAP;

`ifdef SEQ_TIMEOUT_EN
    logic [3:0] wait_cnt;
    logic       waiting;
    assign waiting = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);
    assign timeout = waiting && wait_cnt == 4'd14;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt <= 4'd0;
        else        wait_cnt <= waiting ? wait_cnt + 4'd1 : 4'd0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  state_nxt = ir_we ? ST_DECODE : timeout ? ST_TRAP : ST_FETCH;
            ST_DECODE: state_nxt = legal ? ST_EXEC : ST_TRAP;
            ST_EXEC:   state_nxt = is_r ? ST_WB : (is_ld || is_st) ? ST_MEM : beq_ok ? ST_FETCH : ST_TRAP;
            ST_MEM:    state_nxt = dmem_ack ? (is_st ? ST_FETCH : ST_WB) : timeout ? ST_TRAP : ST_MEM;
            ST_WB:     state_nxt = ST_FETCH;
            default:   state_nxt = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            ir    <= 32'd0;
            go    <= 1'b0;
        end else begin
            state <= state_nxt;
            go    <= 1'b1;
            if (ir_we) ir <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench, expected per-cycle control vectors queued then compared.
module tb_multicycle_sequencer;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
    logic        imem_req, dmem_req, dmem_we, alu_src, mem_to_reg;
    logic        ir_we, reg_we, pc_we, pc_src, trap;
    logic [3:0]  alu_op;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, ir_we, dmem_req, dmem_we;
        logic [3:0] alu_op;
        logic       alu_src, mem_to_reg, reg_we, pc_we, pc_src, trap;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        iack, dack, zero, chk;
        vec_t        exp;
    } step_t;

    step_t       q[$];
    logic [31:0] cur;
    logic        cur_zero;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .alu_op(alu_op), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .ir_we(ir_we),
        .reg_we(reg_we), .pc_we(pc_we), .pc_src(pc_src), .state(state), .trap(trap)
    );

    function automatic vec_t v(input logic [2:0] st);
        vec_t r = '0;
        r.st   = st;
        r.trap = st == 3'd7;
        return r;
    endfunction

    function automatic vec_t sample();
        return {state, imem_req, ir_we, dmem_req, dmem_we, alu_op, alu_src, mem_to_reg, reg_we, pc_we, pc_src, trap};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input vec_t e, input logic iack, input logic dack, input logic chk);
        step_t s;
        s.rdata = cur; s.iack = iack; s.dack = dack; s.zero = cur_zero; s.chk = chk; s.exp = e;
        q.push_back(s);
    endtask

    task automatic push_trap(input int n, input logic noise);
        for (int i = 0; i < n; i++) push(v(3'd7), noise, noise, 1'b0);
    endtask

    // Independent model of the expected cycle-by-cycle control trace for one instruction
    task automatic expect_instr(input logic [31:0] instr, input int iw, input int dw,
                                input logic zero, input logic noise);
        vec_t       e;
        logic [6:0] op = instr[6:0];
        logic [2:0] f3 = instr[14:12];
        cur = instr; cur_zero = zero;
        for (int i = 0; i < iw; i++) begin
            e = v(3'd0); e.imem_req = 1'b1; push(e, 1'b0, noise, 1'b0);
        end
        e = v(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1; push(e, 1'b1, noise, 1'b0);
        push(v(3'd1), noise, noise, 1'b0);
        if (!(op == 7'h33 || op == 7'h03 || op == 7'h23 || op == 7'h63)) begin
            push_trap(3, noise);
            return;
        end
        e = v(3'd2);
        if (op == 7'h33) begin
            e.alu_op = {instr[30], f3}; push(e, noise, noise, 1'b1);
            e.st = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1; push(e, noise, noise, 1'b1);
        end else if (op == 7'h63) begin
            if (f3 != 3'd0) begin
                push(e, noise, noise, 1'b0);
                push_trap(3, noise);
            end else begin
                e.alu_op = 4'h8; e.pc_we = 1'b1; e.pc_src = zero; push(e, noise, noise, 1'b1);
            end
        end else begin
            e.alu_src = 1'b1; e.mem_to_reg = op == 7'h03; e.dmem_we = op == 7'h23;
            push(e, noise, noise, 1'b1);
            e.st = 3'd3; e.dmem_req = 1'b1;
            for (int i = 0; i < dw; i++) push(e, noise, 1'b0, 1'b1);
            e.pc_we = op == 7'h23; push(e, noise, 1'b1, 1'b1);
            if (op == 7'h03) begin
                e.st = 3'd4; e.dmem_req = 1'b0; e.pc_we = 1'b1; e.reg_we = 1'b1;
                push(e, noise, noise, 1'b1);
            end
        end
    endtask

    task automatic drain(input string tag);
        step_t s;
        vec_t  o;
        while (q.size() > 0) begin
            s = q.pop_front();
            imem_rdata = s.rdata; imem_ack = s.iack; dmem_ack = s.dack; alu_zero = s.zero;
            @(negedge clk);
            o = sample();
            if (!s.chk) begin
                o.dmem_we = 1'b0; o.alu_op = 4'h0; o.alu_src = 1'b0; o.mem_to_reg = 1'b0;
                s.exp.dmem_we = 1'b0; s.exp.alu_op = 4'h0; s.exp.alu_src = 1'b0; s.exp.mem_to_reg = 1'b0;
            end
            check(tag, 32'(o), 32'(s.exp));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] instr, input int iw, input int dw,
                       input logic zero, input logic noise);
        expect_instr(instr, iw, dw, zero, noise);
        drain(tag);
    endtask

    task automatic do_reset(input string tag);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        check(tag, 32'(sample()), 32'(v(3'd0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        do_reset("reset");
        run("add", 32'h002081B3, 0, 0, 1'b0, 1'b0);
        run("sub", 32'h402081B3, 0, 0, 1'b0, 1'b1);
        run("and", 32'h0020F1B3, 2, 0, 1'b0, 1'b0);
        run("lw_wait3", 32'h0000A183, 0, 3, 1'b0, 1'b0);
        run("sw", 32'h0030A023, 0, 0, 1'b0, 1'b1);
        run("beq_taken", 32'h00208063, 0, 0, 1'b1, 1'b0);
        run("beq_not_taken", 32'h00208063, 1, 0, 1'b0, 1'b1);
        run("lw_nowait", 32'h0000A183, 0, 0, 1'b0, 1'b1);
        run("bne_trap", 32'h00209063, 0, 0, 1'b0, 1'b1);
        do_reset("reset_after_bne");
        run("illegal", 32'h0000007F, 0, 0, 1'b0, 1'b1);
        do_reset("reset_after_trap");
        run("add_after_trap", 32'h002081B3, 0, 0, 1'b0, 1'b0);

        cur = 32'h0000A183; cur_zero = 1'b0;
        e = v(3'd0); e.imem_req = 1'b1; e.ir_we = 1'b1; push(e, 1'b1, 1'b0, 1'b0);
        push(v(3'd1), 1'b0, 1'b0, 1'b0);
        e = v(3'd2); e.alu_src = 1'b1; e.mem_to_reg = 1'b1; push(e, 1'b0, 1'b0, 1'b1);
        e.st = 3'd3; e.dmem_req = 1'b1; push(e, 1'b0, 1'b0, 1'b1);
        drain("lw_to_mem");
        check("mid_mem_state", 32'(state), 32'd3);
        check("mid_mem_dmem_req", 32'(dmem_req), 32'd1);
        do_reset("async_reset_mid_mem");

        cur = 32'h002081B3; cur_zero = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            e = v(3'd0); e.imem_req = 1'b1; push(e, 1'b0, 1'b0, 1'b0);
        end
        push_trap(3, 1'b1);
        drain("fetch_timeout");
        do_reset("reset_after_timeout");
`else
        for (int i = 0; i < 20; i++) begin
            e = v(3'd0); e.imem_req = 1'b1; push(e, 1'b0, 1'b0, 1'b0);
        end
        drain("fetch_wait_forever");
`endif
        run("add_final", 32'h002081B3, 0, 0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 The block SHALL expose: imem_rdata  in  32  fetched instruction word; imem_req  out  1  instruction fetch request; imem_ack  in  1  fetch data valid.
REQ-003 The block SHALL expose: dmem_req  out  1  data access request; dmem_we  out  1  1=store, 0=load; dmem_ack  in  1  data access complete.
REQ-004 The block SHALL expose: alu_zero  in  1  ALU zero flag; alu_op  out  4  ALU operation; alu_src  out  1  1=immediate operand; mem_to_reg  out  1  writeback from memory.
REQ-005 The block SHALL expose: ir_we  out  1  instruction register load; reg_we  out  1  register file write; pc_we  out  1  PC update; pc_src  out  1  1=branch target.
REQ-006 The block SHALL expose: state  out  3  current FSM state; trap  out  1  sticky illegal-opcode/timeout flag.

Function
REQ-007 The FSM SHALL have states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-008 FETCH: imem_req=1 until imem_ack; on the ack cycle ir_we=1 and the internal IR captures imem_rdata; next state DECODE.
REQ-009 DECODE SHALL last exactly one cycle; opcodes 0x33, 0x03, 0x23 and 0x63 SHALL go to EXEC; any other opcode SHALL go to TRAP.
REQ-010 EXEC for 0x33 (R-type): alu_op={IR[30],IR[14:12]}, alu_src=0; next WB.
REQ-011 EXEC for 0x03/0x23: alu_op=ALU_ADD (4'h0), alu_src=1; next MEM.
REQ-012 EXEC for 0x63 (beq, func3=0): alu_op=ALU_SUB (4'h8), alu_src=0, pc_we=1, pc_src=alu_zero; next FETCH. Other func3 values SHALL go to TRAP.
REQ-013 MEM: dmem_req=1 held until dmem_ack; dmem_we=1 for 0x23 and 0 for 0x03; on ack a load SHALL go to WB, and a store SHALL assert pc_we=1 and go to FETCH.
REQ-014 WB SHALL last one cycle with reg_we=1 and pc_we=1, pc_src=0, mem_to_reg=1 for loads and 0 for R-type; next FETCH.
REQ-015 pc_we SHALL pulse exactly once per retired instruction; reg_we SHALL never assert outside WB.
REQ-016 An ack arriving in the first request cycle SHALL advance the FSM on that edge; an ack seen while no request is pending SHALL be ignored.
REQ-017 TRAP SHALL be absorbing: trap=1 and all strobes 0 until reset.
REQ-018 Latency SHALL be: R-type 4 cycles, load 5, store 4, branch 3, each with zero-wait memory.
REQ-019 alu_op, alu_src, mem_to_reg and dmem_we SHALL hold their EXEC values through MEM and WB.

Reset
REQ-020 When rst_n=0, the block SHALL asynchronously force state=FETCH, IR=0, trap=0, and all strobes and alu_op to 0; reset asserted mid-MEM SHALL drop dmem_req immediately.
REQ-021 After rst_n deasserts, the first rising edge SHALL begin a fetch with imem_req=1.

Configuration
REQ-022 With SEQ_TIMEOUT_EN defined, a 4-bit wait counter SHALL be cleared on entry to FETCH or MEM and increment each cycle without ack; reaching 15 SHALL enter TRAP.
REQ-023 Without SEQ_TIMEOUT_EN, the FSM SHALL wait indefinitely for acks, and the counter SHALL not exist.

Structure
REQ-024 Shared package seq_pkg SHALL hold the state encodings, the opcode constants (OP_R=7'h33, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63) and ALU_ADD/ALU_SUB.
REQ-025 The combinational opcode decoder SHALL be one sub-module, seq_decode, which maps IR to an instruction class and a legal flag; the FSM and registers SHALL live in the top module.

Verification
REQ-026 Reset, then add x3,x1,x2 (0x002081B3) with ack on the first request -> states 0,1,2,4, then 0; reg_we=1 for one cycle; alu_op=0.
REQ-027 sub (0x402081B3) -> alu_op=4'h8 in EXEC; and (func3=7) -> alu_op=4'h7.
REQ-028 lw (0x0000A183) with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with mem_to_reg=1.
REQ-029 sw (0x0030A023) -> dmem_we=1, no reg_we, pc_we on the ack cycle; beq with alu_zero=1 -> pc_we=1 and pc_src=1 in EXEC.
REQ-030 Opcode 0x7F -> TRAP after DECODE, trap=1 sticky; rst_n pulsed mid-MEM -> dmem_req=0 with no clock edge; with SEQ_TIMEOUT_EN and no imem_ack -> TRAP after 15 cycles.
